// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute control unit for the 9-bit accumulator datapath.
// Owns the program counter and sequences each instruction as FETCH then EXEC.
// It gates the regA/regB load enables and resolves conditional jumps from the
// registered ALU flags. It also provides HALT and a saturating retired-instruction count.
// Optional build macro PC_SEQ_STEP_EN adds a 'step' input and a PAUSE state
// for single-stepping: each instruction then waits for a rising edge of step.
module pc_sequencer #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef PC_SEQ_STEP_EN
    input  logic              step,
`endif
    input  logic [8:0]        instr_in,
    input  logic [7:0]        alu_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic              load_a,
    output logic              load_b,
    output logic              mux_sel,
    output logic [1:0]        alu_sel,
    output logic [3:0]        literal,
    output logic              flag_z,
    output logic              flag_n,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    localparam int unsigned IR_W = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
`ifdef PC_SEQ_STEP_EN
        S_HALT,
        S_PAUSE
`else
        S_HALT
`endif
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [IR_W-1:0]   ir;

    logic              is_jump_c;
    logic              is_halt_c;
    logic              take_c;
    logic [ADDR_W-1:0] pc_inc_c;
    logic [CNT_W-1:0]  retired_sat_c;

    // Instruction decode and next-value helpers
    assign is_jump_c     = ir[8] & (ir[7:6] == 2'b00);
    assign is_halt_c     = is_jump_c & (ir[5:4] == 2'b11);
    assign pc_inc_c      = pc + ADDR_W'(1);
    assign retired_sat_c = (retired == {CNT_W{1'b1}}) ? retired : retired + CNT_W'(1);

    // Jump condition from the registered zero flag
    always_comb begin
        take_c = 1'b0;
        case (ir[5:4])
            2'b00:   take_c = 1'b1;
            2'b01:   take_c = flag_z;
            2'b10:   take_c = ~flag_z;
            default: take_c = 1'b0;
        endcase
    end

`ifdef PC_SEQ_STEP_EN
    logic step_q;
    logic step_rise_c;

    // Registered copy of step for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_rise_c = step & ~step_q;
`endif

    // Sequencer state, program counter, instruction register, flags and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            retired <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir    <= instr_in;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_halt_c) begin
                        state <= S_HALT;
                    end else begin
                        if (is_jump_c) begin
                            pc <= take_c ? ADDR_W'(ir[3:0]) : pc_inc_c;
                        end else begin
                            pc <= pc_inc_c;
                            if (ir[7] | ir[6]) begin
                                flag_z <= (alu_in == 8'd0);
                                flag_n <= alu_in[7];
                            end
                        end
                        retired <= retired_sat_c;
`ifdef PC_SEQ_STEP_EN
                        state   <= S_PAUSE;
`else
                        state   <= S_FETCH;
`endif
                    end
                end
                S_HALT: begin
                    if (start) begin
                        pc      <= '0;
                        retired <= '0;
                        flag_z  <= 1'b0;
                        flag_n  <= 1'b0;
                        state   <= S_FETCH;
                    end
                end
`ifdef PC_SEQ_STEP_EN
                S_PAUSE: begin
                    if (start) begin
                        pc      <= '0;
                        retired <= '0;
                        flag_z  <= 1'b0;
                        flag_n  <= 1'b0;
                        state   <= S_FETCH;
                    end else if (step_rise_c) begin
                        state <= S_FETCH;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Load enables follow the state register so they drop with reset immediately
    assign load_a  = (state == S_EXEC) & ~is_jump_c & ir[6];
    assign load_b  = (state == S_EXEC) & ~is_jump_c & ir[7];

    // Datapath controls straight from the instruction register
    assign mux_sel = ir[8];
    assign alu_sel = ir[5:4];
    assign literal = ir[3:0];

    // Status
    assign pc_out  = pc;
    assign busy    = (state == S_FETCH) | (state == S_EXEC);
    assign halted  = (state == S_HALT);

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Control unit that fetches and executes one 9-bit instruction at a time for the accumulator datapath (PC, instruction memory, regA, regB, muxB, ALU). It owns the program counter and sequences each instruction as a two-cycle FETCH/EXEC pair. It gates the regA/regB load enables and adds conditional jumps driven by registered ALU flags. It also provides halt and a retired-instruction counter.

Parameters:
ADDR_W, 4, program counter / instruction memory address width
CNT_W, 8, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-low
start  input  1  level-sampled; begins or restarts execution from address 0
instr_in  input  9  instruction memory data for address pc_out
alu_in  input  8  ALU result, combinational from current regA/muxB
pc_out  output  ADDR_W  program counter, drives instruction memory address
load_a  output  1  regA load enable
load_b  output  1  regB load enable
mux_sel  output  1  muxB select, = ir[8]
alu_sel  output  2  ALU op select, = ir[5:4]
literal  output  4  immediate, = ir[3:0]
flag_z  output  1  registered zero flag
flag_n  output  1  registered negative flag (result bit 7)
busy  output  1  high in FETCH or EXEC
halted  output  1  high in HALT
retired  output  CNT_W  saturating count of executed non-HALT instructions

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=0, ir=0, flags=0, retired=0. All outputs 0.
- IDLE: start=1 -> FETCH next edge. Otherwise stay.
- FETCH (1 cycle): ir <= instr_in. -> EXEC.
- EXEC (1 cycle): decode ir.
  - Jump class: ir[8]=1 and ir[7:6]=00. Condition is ir[5:4]:
    - 00 JMP: always taken.
    - 01 JEQ: taken if flag_z=1.
    - 10 JNE: taken if flag_z=0.
    - 11 HALT: no condition; see below.
  - Taken jump: pc <= ir[3:0] (zero-extended/truncated to ADDR_W). Not taken: pc <= pc+1.
  - load_a/load_b forced 0 for jump class. Flags unchanged.
  - HALT: pc unchanged, retired unchanged, -> HALT.
  - Non-jump: load_a=ir[6], load_b=ir[7], asserted only during EXEC (combinational from state and ir); the registers capture at the end of EXEC.
    - If ir[7] or ir[6] is set: flag_z <= (alu_in==0), flag_n <= alu_in[7] at the same edge.
    - pc <= pc+1.
  - All non-HALT EXEC: retired <= retired+1, saturating at 2^CNT_W-1. -> FETCH.
- load_a/load_b are 0 in every state except EXEC.
- mux_sel/alu_sel/literal are driven from ir in all states.
- pc wraps modulo 2^ADDR_W: 15+1 -> 0 with the default width. No trap.
- HALT: halted=1, busy=0. start=1 -> pc<=0, retired<=0, flags<=0, -> FETCH.
- start is ignored in FETCH/EXEC.
- rst_n low in any state (including mid-EXEC) returns to reset values immediately. Load enables drop asynchronously, so no register write occurs on the following edge.

Optional Feature:
PC_SEQ_STEP_EN
- Defined:
  - Adds input port step (1 bit) and state PAUSE.
  - A non-HALT EXEC goes to PAUSE instead of FETCH.
  - PAUSE -> FETCH on a rising edge of step, detected via a registered step_q that resets to 0. Holding step high does not re-trigger.
  - busy=0 in PAUSE.
  - start in PAUSE behaves as in HALT (restart from 0).
- Undefined: no step port, no PAUSE state, free-running two cycles per instruction.

Test Plan:
- Reset mid-run: assert rst_n=0 during EXEC of 0x143 -> load_a drops same cycle, pc_out=0, retired=0, regA unchanged after release.
- Literal load: mem[0]=0x143, start, bench ALU alu_in=3 -> FETCH then EXEC with load_a=1, mux_sel=1, literal=3; flag_z=0, flag_n=0, pc_out=1, retired=1.
- JMP: mem[1]=0x105 -> load_a=load_b=0 during its EXEC, pc_out=5 next edge, flags unchanged.
- JEQ taken/not taken: load with alu_in=0x00 then 0x118 -> pc_out=8. Repeat with alu_in=0x80 -> flag_n=1, flag_z=0, pc_out=pc+1.
- HALT/restart: 0x130 -> halted=1, busy=0, pc_out held, retired unchanged. start=1 -> pc_out=0, retired=0, busy=1.
- Wrap and saturation: non-jump at address 15 -> pc_out=0. Self-loop JMP at 0 (0x100) for 300 instructions -> retired=255 and holds.
